neurosa_run_sequencer: RTL and testbench
========================================

Name: neurosa_run_sequencer

Overview:
- Host-facing controller that drives the neuron array's single `ins`/`outs` bus through a full annealing job.
- Job steps: size word, BEGIN_WR header, gapless per-neuron config stream, then alternating run windows (rd low) and probe readouts (rd high).
- Readout words are forwarded to the host as a snapshot-tagged result stream.
- Sits between the host interface and the neuron-array top.

Parameters:
- FP_DATA_WIDTH, 16, bus word width (ins/outs/cfg/result).
- NEURON_ID_WIDTH, 9, width of the neuron count / id.
- WORDS_PER_NEURON, 4, config words per neuron, in order Vmem, mu, neuronI, Q.
- SIZE_HOLD, 2, cycles the size word is held on ins before the header.
- RUN_CNT_WIDTH, 24, width of the run-window length.
- SNAP_CNT_WIDTH, 8, width of the snapshot count.

Ports:
- clk  in  1  sole clock
- reset  in  1  reset
- start  in  1  job start pulse; accepted only in IDLE
- num_neurons  in  NEURON_ID_WIDTH  active neuron count, sampled on start
- run_cycles  in  RUN_CNT_WIDTH  cycles per run window, sampled on start
- num_snapshots  in  SNAP_CNT_WIDTH  run/read iterations, sampled on start
- cfg_valid  in  1  config word valid
- cfg_ready  out  1  config word accepted
- cfg_data  in  FP_DATA_WIDTH  config word
- ins  out  FP_DATA_WIDTH  array input bus, registered
- rd  out  1  array readout request, registered
- outs  in  FP_DATA_WIDTH  array probe word
- readDone  in  1  array last-readout-word flag
- res_valid  out  1  result word valid; no backpressure
- res_data  out  FP_DATA_WIDTH  probe word
- res_last  out  1  last word of a snapshot
- res_snap  out  SNAP_CNT_WIDTH  snapshot index, 0-based
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle job-complete pulse
- err_cfg  out  1  one-cycle pulse: start rejected
- err_underflow  out  1  sticky: cfg stream gap during LOAD

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high. On reset every output is 0 and the FSM goes to IDLE. The array must be reset in the same cycle; a reset mid-job abandons the job with no result flush.
- IDLE:
  - ins=0, rd=0.
  - start is rejected (err_cfg pulse, stay IDLE) if num_neurons<1, num_neurons>2^NEURON_ID_WIDTH-1, run_cycles==0 or num_snapshots==0.
  - Otherwise latch all three inputs and go to SIZE.
- SIZE: ins = zero-extended num_neurons for SIZE_HOLD cycles, then HDR.
- HDR: ins = all-ones (BEGIN_WR) for exactly 1 cycle, then LOAD.
- LOAD:
  - cfg_ready=1 for WORDS_PER_NEURON*num_neurons cycles (down counter).
  - Each cycle: ins <= cfg_data on the next edge.
  - If cfg_valid=0 in any LOAD cycle: set err_underflow, go to ERR.
  - After the last word, go to RUN with snap=0.
- RUN: rd=0, ins=0 for run_cycles cycles, then READ.
- READ:
  - rd=1 from the first READ cycle.
  - `arr_rd` is a flag delayed one cycle from rd. While arr_rd=1, outs/readDone are captured each cycle and presented one cycle later as res_valid=1, res_data=outs, res_last=readDone, res_snap=snap.
  - When readDone is sampled 1: rd drops on the next edge and snap increments.
  - If snap+1 < num_snapshots go to RUN, else DONE.
  - readDone is never expected before arr_rd=1; if seen, it is ignored.
- DONE: done=1 for 1 cycle, then IDLE. The final res_valid may coincide with done.
- ERR: ins=0, rd=0, busy=1, cfg_ready=0. Exited only by reset.
- Boundaries:
  - start while busy is ignored, with no error.
  - num_neurons=1 gives exactly 4 LOAD cycles.
  - run_cycles=1 gives a 1-cycle RUN.
  - snap counter wraps never (bounded by num_snapshots).
  - Down counters reload on state entry and never underflow past 0.

Decomposition:
- Package neurosa_pkg holds:
  - state enum {IDLE, SIZE, HDR, LOAD, RUN, READ, DONE, ERR}
  - BEGIN_WR = all-ones constant
  - WORDS_PER_NEURON
  - width localparams
- One natural sub-module: neurosa_down_counter (load value, enable, zero flag). It is instantiated for the SIZE/LOAD and RUN lengths.

Test Plan:
- start, num_neurons=3, run=5, snaps=1, gapless cfg 12 words -> ins shows 0003 x2, FFFF x1, 12 words in order; rd rises exactly 5 cycles after the last word; done once.
- READ with stub array returning 2 words (readDone on 2nd) -> res_valid x2 with res_last on the 2nd only, res_snap=0; rd low the cycle after readDone.
- snaps=3 -> three RUN/READ pairs; res_snap values 0,1,2; done only after the 3rd res_last.
- cfg_valid dropped at LOAD word 7 -> err_underflow=1 and held, cfg_ready=0, rd=0 until reset; reset clears all outputs to 0.
- start with num_neurons=0, then with run_cycles=0 -> err_cfg pulse each time, busy stays 0, ins stays 0.
- reset asserted during RUN of snapshot 1 -> next cycle all outputs 0, FSM in IDLE; a fresh start runs a full job correctly.

Source files
------------

// File: rtl/neurosa_pkg.sv
// Shared types and constants for the neuron-array run sequencer.
package neurosa_pkg;

   localparam int FP_DATA_WIDTH    = 16;
   localparam int NEURON_ID_WIDTH  = 9;
   localparam int WORDS_PER_NEURON = 4;
   localparam int SIZE_HOLD        = 2;
   localparam int RUN_CNT_WIDTH    = 24;
   localparam int SNAP_CNT_WIDTH   = 8;
   localparam int LEN_CNT_WIDTH    = NEURON_ID_WIDTH + $clog2(WORDS_PER_NEURON);

   localparam logic [FP_DATA_WIDTH-1:0] BEGIN_WR = '1;

   typedef enum logic [2:0] {
      IDLE,
      SIZE,
      HDR,
      LOAD,
      RUN,
      READ,
      DONE,
      ERR
   } state_e;

   // Reload value for the LOAD window: total config words minus one.
   function automatic logic [LEN_CNT_WIDTH-1:0] load_words_m1(input logic [NEURON_ID_WIDTH-1:0] n);
      return LEN_CNT_WIDTH'(n) * LEN_CNT_WIDTH'(WORDS_PER_NEURON) - LEN_CNT_WIDTH'(1);
   endfunction

endpackage

// File: rtl/neurosa_down_counter.sv
// Loadable down counter that saturates at zero; zero flag marks the last cycle of a window.
module neurosa_down_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             en_i,
   output logic             zero_o
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (en_i && (count_q != '0)) begin
         count_q <= count_q - WIDTH'(1);
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/neurosa_run_sequencer.sv
// Drives the neuron array through size/header/config load, then alternating run and readout windows.
module neurosa_run_sequencer
   import neurosa_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [NEURON_ID_WIDTH-1:0] num_neurons,
   input  logic [RUN_CNT_WIDTH-1:0]   run_cycles,
   input  logic [SNAP_CNT_WIDTH-1:0]  num_snapshots,
   input  logic                       cfg_valid,
   output logic                       cfg_ready,
   input  logic [FP_DATA_WIDTH-1:0]   cfg_data,
   output logic [FP_DATA_WIDTH-1:0]   ins,
   output logic                       rd,
   input  logic [FP_DATA_WIDTH-1:0]   outs,
   input  logic                       readDone,
   output logic                       res_valid,
   output logic [FP_DATA_WIDTH-1:0]   res_data,
   output logic                       res_last,
   output logic [SNAP_CNT_WIDTH-1:0]  res_snap,
   output logic                       busy,
   output logic                       done,
   output logic                       err_cfg,
   output logic                       err_underflow
);

   state_e                     state_q, state_d;
   logic [NEURON_ID_WIDTH-1:0] num_neurons_q;
   logic [RUN_CNT_WIDTH-1:0]   run_cycles_q;
   logic [SNAP_CNT_WIDTH-1:0]  num_snapshots_q;
   logic [SNAP_CNT_WIDTH-1:0]  snap_q;
   logic [FP_DATA_WIDTH-1:0]   ins_q, ins_d;
   logic                       rd_q, rd_d;
   logic                       arr_rd_q;
   logic                       res_valid_q, res_last_q;
   logic [FP_DATA_WIDTH-1:0]   res_data_q;
   logic [SNAP_CNT_WIDTH-1:0]  res_snap_q;
   logic                       err_cfg_q, err_cfg_d;
   logic                       err_underflow_q;

   logic                       params_ok, latch_params, underflow_set, snap_inc;
   logic [SNAP_CNT_WIDTH:0]    snap_next;
   logic                       more_snaps;

   logic                       len_load, len_en, len_zero;
   logic [LEN_CNT_WIDTH-1:0]   len_val;
   logic                       run_load, run_en, run_zero;

   // A NEURON_ID_WIDTH-bit count can never exceed 2^W-1, so only zero is rejected.
   assign params_ok  = (num_neurons != '0) && (run_cycles != '0) && (num_snapshots != '0);
   assign snap_next  = {1'b0, snap_q} + 1'b1;
   assign more_snaps = (snap_next < {1'b0, num_snapshots_q});

   neurosa_down_counter #(.WIDTH(LEN_CNT_WIDTH)) u_len_cnt (
      .clk        (clk),
      .reset      (reset),
      .load_i     (len_load),
      .load_val_i (len_val),
      .en_i       (len_en),
      .zero_o     (len_zero)
   );

   neurosa_down_counter #(.WIDTH(RUN_CNT_WIDTH)) u_run_cnt (
      .clk        (clk),
      .reset      (reset),
      .load_i     (run_load),
      .load_val_i (run_cycles_q - RUN_CNT_WIDTH'(1)),
      .en_i       (run_en),
      .zero_o     (run_zero)
   );

   always_comb begin
      state_d       = state_q;
      ins_d         = '0;
      len_load      = 1'b0;
      len_val       = '0;
      len_en        = 1'b0;
      run_load      = 1'b0;
      run_en        = 1'b0;
      err_cfg_d     = 1'b0;
      latch_params  = 1'b0;
      underflow_set = 1'b0;
      snap_inc      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (params_ok) begin
                  latch_params = 1'b1;
                  len_load     = 1'b1;
                  len_val      = LEN_CNT_WIDTH'(SIZE_HOLD - 1);
                  state_d      = SIZE;
               end else begin
                  err_cfg_d = 1'b1;
               end
            end
         end
         SIZE: begin
            ins_d  = FP_DATA_WIDTH'(num_neurons_q);
            len_en = 1'b1;
            if (len_zero) state_d = HDR;
         end
         HDR: begin
            ins_d    = BEGIN_WR;
            len_load = 1'b1;
            len_val  = load_words_m1(num_neurons_q);
            state_d  = LOAD;
         end
         LOAD: begin
            if (cfg_valid) begin
               ins_d  = cfg_data;
               len_en = 1'b1;
               if (len_zero) begin
                  run_load = 1'b1;
                  state_d  = RUN;
               end
            end else begin
               underflow_set = 1'b1;
               state_d       = ERR;
            end
         end
         RUN: begin
            run_en = 1'b1;
            if (run_zero) state_d = READ;
         end
         READ: begin
            if (arr_rd_q && readDone) begin
               snap_inc = 1'b1;
               run_load = more_snaps;
               state_d  = more_snaps ? RUN : DONE;
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = ERR;
         default: state_d = IDLE;
      endcase
      rd_d = (state_d == READ);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         num_neurons_q   <= '0;
         run_cycles_q    <= '0;
         num_snapshots_q <= '0;
         snap_q          <= '0;
         ins_q           <= '0;
         rd_q            <= 1'b0;
         arr_rd_q        <= 1'b0;
         res_valid_q     <= 1'b0;
         res_data_q      <= '0;
         res_last_q      <= 1'b0;
         res_snap_q      <= '0;
         err_cfg_q       <= 1'b0;
         err_underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ins_q       <= ins_d;
         rd_q        <= rd_d;
         // Cleared together with rd so the word after readDone is never captured.
         arr_rd_q    <= rd_q & rd_d;
         err_cfg_q   <= err_cfg_d;
         res_valid_q <= arr_rd_q;
         if (underflow_set) err_underflow_q <= 1'b1;
         if (latch_params) begin
            num_neurons_q   <= num_neurons;
            run_cycles_q    <= run_cycles;
            num_snapshots_q <= num_snapshots;
            snap_q          <= '0;
         end else if (snap_inc) begin
            snap_q <= snap_q + SNAP_CNT_WIDTH'(1);
         end
         if (arr_rd_q) begin
            res_data_q <= outs;
            res_last_q <= readDone;
            res_snap_q <= snap_q;
         end
      end
   end

   assign ins           = ins_q;
   assign rd            = rd_q;
   assign cfg_ready     = (state_q == LOAD);
   assign busy          = (state_q != IDLE);
   assign done          = (state_q == DONE);
   assign res_valid     = res_valid_q;
   assign res_data      = res_data_q;
   assign res_last      = res_last_q;
   assign res_snap      = res_snap_q;
   assign err_cfg       = err_cfg_q;
   assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_neurosa_run_sequencer.sv
// Scoreboard bench for neurosa_run_sequencer with a stub neuron array on the ins/outs bus.
module tb_neurosa_run_sequencer;

   localparam int SZ_HOLD = 2;
   localparam int WPN     = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [8:0]  num_neurons;
   logic [23:0] run_cycles;
   logic [7:0]  num_snapshots;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [15:0] cfg_data;
   logic [15:0] ins;
   logic        rd;
   logic [15:0] outs;
   logic        readDone;
   logic        res_valid;
   logic [15:0] res_data;
   logic        res_last;
   logic [7:0]  res_snap;
   logic        busy;
   logic        done;
   logic        err_cfg;
   logic        err_underflow;

   neurosa_run_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .num_neurons   (num_neurons),
      .run_cycles    (run_cycles),
      .num_snapshots (num_snapshots),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .cfg_data      (cfg_data),
      .ins           (ins),
      .rd            (rd),
      .outs          (outs),
      .readDone      (readDone),
      .res_valid     (res_valid),
      .res_data      (res_data),
      .res_last      (res_last),
      .res_snap      (res_snap),
      .busy          (busy),
      .done          (done),
      .err_cfg       (err_cfg),
      .err_underflow (err_underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic        last;
      logic [7:0]  snap;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_miss = 0;
   int   lasts_seen = 0;
   int   done_cnt = 0;
   int   drop_idx = -1;
   int   stub_nwords = 2;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Config source: presents word C000+idx whenever the DUT is ready, optionally dropping one.
   initial begin : cfg_driver
      int idx;
      idx = 0;
      forever begin
         @(negedge clk);
         if (!busy) idx = 0;
         if (cfg_ready) begin
            cfg_data  = 16'(32'hC000 + idx);
            cfg_valid = (idx != drop_idx);
            if (cfg_valid) idx++;
         end else begin
            cfg_valid = 1'b0;
            cfg_data  = '0;
         end
      end
   end

   // Stub array: one cycle after rd is seen high, returns stub_nwords words, readDone on the last.
   initial begin : stub_array
      int  s_snap, s_idx;
      bit  s_fin, rd_prev;
      s_snap = 0; s_idx = 0; s_fin = 0; rd_prev = 0;
      forever begin
         @(posedge clk);
         #1;
         if (reset || !busy) begin
            s_snap = 0; s_idx = 0; s_fin = 0; rd_prev = 0;
            outs = '0; readDone = 1'b0;
         end else begin
            if (rd_prev && !s_fin) begin
               outs     = 16'(32'hA000 + s_snap * 256 + s_idx);
               readDone = (s_idx == stub_nwords - 1);
               if (readDone) s_fin = 1;
               s_idx++;
            end else begin
               outs     = '0;
               readDone = 1'b0;
            end
            if (!rd) begin
               if (s_fin) s_snap++;
               s_fin = 0;
               s_idx = 0;
            end
            rd_prev = rd;
         end
      end
   end

   // Result monitor: pops the scoreboard on every presented result word.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (res_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_res", 64'(res_data), 64'(0));
            end else begin
               e = sb.pop_front();
               chk("res_data", 64'(res_data), 64'(e.data));
               chk("res_last", 64'(res_last), 64'(e.last));
               chk("res_snap", 64'(res_snap), 64'(e.snap));
               chk("rd_during_res", 64'(rd), 64'(!e.last));
               if (res_last) lasts_seen++;
            end
         end
         if (done) begin
            done_cnt++;
            chk("sb_empty_at_done", 64'(sb.size()), 64'(0));
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check_zero(input string name);
      chk(name, 64'({cfg_ready, ins, rd, res_valid, res_data, res_last, res_snap,
                     busy, done, err_cfg, err_underflow}), 64'(0));
   endtask

   task automatic push_exp(input int snaps, input int nw);
      exp_t e;
      for (int s = 0; s < snaps; s++) begin
         for (int i = 0; i < nw; i++) begin
            e.data = 16'(32'hA000 + s * 256 + i);
            e.last = (i == nw - 1);
            e.snap = 8'(s);
            sb.push_back(e);
         end
      end
   endtask

   task automatic do_start(input int n, input int run, input int snaps);
      @(negedge clk);
      start         = 1'b1;
      num_neurons   = 9'(n);
      run_cycles    = 24'(run);
      num_snapshots = 8'(snaps);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_zero("outputs_after_reset");
      reset = 1'b0;
   endtask

   // Full job: optional bus trace from the first SIZE cycle through the first rd rise, then wait for done.
   task automatic run_job(input int n, input int run, input int snaps, input int nw, input bit trace);
      int          kl, base_last, base_done;
      logic [15:0] e_ins;
      bit          ok;
      stub_nwords = nw;
      push_exp(snaps, nw);
      base_last = lasts_seen;
      base_done = done_cnt;
      do_start(n, run, snaps);
      if (trace) begin
         kl = SZ_HOLD + 1 + WPN * n;
         for (int k = 0; k <= kl + run; k++) begin
            if (k == 0)                  e_ins = 16'h0000;
            else if (k <= SZ_HOLD)       e_ins = 16'(n);
            else if (k == SZ_HOLD + 1)   e_ins = 16'hFFFF;
            else if (k <= kl)            e_ins = 16'(32'hC000 + k - SZ_HOLD - 2);
            else                         e_ins = 16'h0000;
            chk($sformatf("ins_k%0d", k), 64'(ins), 64'(e_ins));
            chk($sformatf("rd_k%0d", k), 64'(rd), 64'(k == kl + run));
            if (k < kl + run) @(negedge clk);
         end
      end
      ok = 0;
      for (int c = 0; c < 3000; c++) begin
         if (done) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      chk("done_seen", 64'(ok), 64'(1));
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'(0));
      chk("idle_after_done", 64'(busy), 64'(0));
      chk("snapshots_completed", 64'(lasts_seen - base_last), 64'(snaps));
      chk("done_count", 64'(done_cnt - base_done), 64'(1));
   endtask

   task automatic bad_start(input string name, input int n, input int run, input int snaps);
      do_start(n, run, snaps);
      chk({name, "_err_cfg"}, 64'(err_cfg), 64'(1));
      chk({name, "_busy"}, 64'(busy), 64'(0));
      chk({name, "_ins"}, 64'(ins), 64'(0));
      @(negedge clk);
      chk({name, "_err_cfg_pulse"}, 64'(err_cfg), 64'(0));
      chk({name, "_still_idle"}, 64'(busy), 64'(0));
   endtask

   initial begin : main
      bit ok;
      int base_last;
      reset = 1'b1; start = 1'b0; num_neurons = '0; run_cycles = '0; num_snapshots = '0;
      cfg_valid = 1'b0; cfg_data = '0; outs = '0; readDone = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset_state");
      reset = 1'b0;

      // Basic job with full bus trace.
      run_job(3, 5, 1, 2, 1'b1);

      // Minimum sizes and three snapshots.
      run_job(1, 1, 3, 2, 1'b1);

      // Longer readouts over two snapshots.
      run_job(2, 3, 2, 4, 1'b0);

      // Rejected starts.
      bad_start("zero_neurons", 0, 5, 1);
      bad_start("zero_run", 2, 0, 1);
      bad_start("zero_snaps", 2, 5, 0);

      // Config stream gap at word 7.
      drop_idx = 7;
      do_start(3, 5, 1);
      ok = 0;
      for (int c = 0; c < 100; c++) begin
         if (err_underflow) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      chk("underflow_seen", 64'(ok), 64'(1));
      for (int c = 0; c < 4; c++) begin
         chk("err_underflow_held", 64'(err_underflow), 64'(1));
         chk("err_cfg_ready", 64'(cfg_ready), 64'(0));
         chk("err_rd", 64'(rd), 64'(0));
         chk("err_ins", 64'(ins), 64'(0));
         chk("err_busy", 64'(busy), 64'(1));
         @(negedge clk);
      end
      drop_idx = -1;
      do_reset();

      // Reset during the second run window, after a bad start that must be ignored.
      stub_nwords = 2;
      push_exp(1, 2);
      base_last = lasts_seen;
      do_start(2, 20, 3);
      ok = 0;
      for (int c = 0; c < 500; c++) begin
         if (lasts_seen > base_last) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      chk("first_snapshot_seen", 64'(ok), 64'(1));
      repeat (3) @(negedge clk);
      do_start(0, 0, 0);
      chk("start_while_busy_no_err", 64'(err_cfg), 64'(0));
      chk("start_while_busy_busy", 64'(busy), 64'(1));
      chk("in_run_rd_low", 64'(rd), 64'(0));
      do_reset();
      @(negedge clk);
      chk("idle_after_mid_reset", 64'(busy), 64'(0));

      // Fresh job after the abandoned one.
      run_job(3, 5, 1, 2, 1'b1);

      repeat (3) @(negedge clk);
      chk("sb_drained", 64'(sb.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
